// File: rtl/rx_data_checker.sv
// Receive-side AXIS symbol sink: checks each packet against the Tx format, length and
// modulation rules and keeps saturating statistics for the BER/debug readout.
module rx_data_checker #(
  parameter int BYTES     = 1,
  parameter int EXTRA     = 3,
  parameter int MAX_FRAME = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         MODE_CTRL,
  input  logic [15:0]        payload_length,
  input  logic               clear_stats,
  input  logic [BYTES*8-1:0] data_tdata,
  input  logic               data_tvalid,
  output logic               data_tready,
  input  logic               data_tlast,
  input  logic               data_tuser,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [15:0]        frame_len,
  output logic               frame_is_bpsk,
  output logic [3:0]         frame_err_flags,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        pkt_err_cnt,
  output logic [31:0]        sym_cnt,
  output logic [31:0]        bit_err_cnt
);
  localparam int BITS = BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_IN_FRAME, S_RESYNC} state_t;
  typedef enum logic [1:0] {M_BPSK, M_QPSK, M_MIX} mode_t;

  state_t      r_state;
  mode_t       r_mode;
  logic        r_is_bpsk;
  logic        r_mode_err;
  logic        r_prev_valid;
  logic        r_prev_bpsk;
  logic [16:0] r_exp_len;
  logic [15:0] r_len;
  logic [15:0] r_pkt_errs;

  function automatic mode_t decode_mode(input logic [3:0] m);
    case (m)
      4'b0001: return M_BPSK;
      4'b0010: return M_QPSK;
      default: return M_MIX;
    endcase
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic        w_beat;
  logic        w_close;
  logic        w_to_resync;
  logic        w_is_bpsk;
  logic        w_mode_err_run;
  mode_t       w_mode;
  logic [15:0] w_beat_errs;
  logic [15:0] w_len;
  logic [15:0] w_pkt_errs;
  logic [16:0] w_exp_len;
  logic [3:0]  w_flags;

  assign w_beat = data_tvalid & data_tready;

  // Every data bit should match the sign bit; bit 0 only carries it for BPSK symbols.
  always_comb begin
    w_beat_errs = 16'd0;
    for (int i = 1; i < BITS; i++)
      w_beat_errs = w_beat_errs + {15'd0, data_tdata[i] ^ data_tdata[BITS-1]};
    if (data_tuser)
      w_beat_errs = w_beat_errs + {15'd0, data_tdata[0] ^ data_tdata[BITS-1]};
  end

  // Packet view including the current beat, so a close can be judged in the same cycle.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_is_bpsk      = data_tuser;
      w_mode         = decode_mode(MODE_CTRL);
      w_exp_len      = (data_tuser ? {1'b0, payload_length} : {2'b00, payload_length[15:1]})
                       + 17'(EXTRA);
      w_len          = 16'd1;
      w_pkt_errs     = w_beat_errs;
      w_mode_err_run = 1'b0;
    end else begin
      w_is_bpsk      = r_is_bpsk;
      w_mode         = r_mode;
      w_exp_len      = r_exp_len;
      w_len          = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
      w_pkt_errs     = sat_add16(r_pkt_errs, w_beat_errs);
      w_mode_err_run = r_mode_err | (data_tuser != r_is_bpsk);
    end
    w_to_resync = w_beat & (r_state == S_IN_FRAME) & ~data_tlast & (w_len == 16'(MAX_FRAME));
    w_close     = w_beat & (r_state != S_RESYNC) & (data_tlast | w_to_resync);
    w_flags[0]  = ({1'b0, w_len} != w_exp_len) | w_to_resync;
    w_flags[1]  = (w_pkt_errs != 16'd0);
    w_flags[2]  = w_mode_err_run | ((w_mode == M_BPSK) & ~w_is_bpsk)
                                 | ((w_mode == M_QPSK) & w_is_bpsk);
    w_flags[3]  = (w_mode == M_MIX) & r_prev_valid & (w_is_bpsk == r_prev_bpsk);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_mode          <= M_MIX;
      r_is_bpsk       <= 1'b0;
      r_mode_err      <= 1'b0;
      r_prev_valid    <= 1'b0;
      r_prev_bpsk     <= 1'b0;
      r_exp_len       <= 17'd0;
      r_len           <= 16'd0;
      r_pkt_errs      <= 16'd0;
      data_tready     <= 1'b0;
      frame_done      <= 1'b0;
      frame_ok        <= 1'b0;
      frame_len       <= 16'd0;
      frame_is_bpsk   <= 1'b0;
      frame_err_flags <= 4'd0;
      pkt_cnt         <= 32'd0;
      pkt_err_cnt     <= 32'd0;
      sym_cnt         <= 32'd0;
      bit_err_cnt     <= 32'd0;
    end else begin
      data_tready <= 1'b1;
      frame_done  <= 1'b0;
      if (w_beat) begin
        sym_cnt <= sat_add32(sym_cnt, 32'd1);
        case (r_state)
          S_IDLE, S_IN_FRAME: begin
            bit_err_cnt <= sat_add32(bit_err_cnt, {16'd0, w_beat_errs});
            r_is_bpsk   <= w_is_bpsk;
            r_mode      <= w_mode;
            r_exp_len   <= w_exp_len;
            r_len       <= w_len;
            r_pkt_errs  <= w_pkt_errs;
            r_mode_err  <= w_mode_err_run;
            if (w_close) begin
              frame_done      <= 1'b1;
              frame_ok        <= (w_flags == 4'd0);
              frame_len       <= w_len;
              frame_is_bpsk   <= w_is_bpsk;
              frame_err_flags <= w_flags;
              pkt_cnt         <= sat_add32(pkt_cnt, 32'd1);
              if (w_flags != 4'd0)
                pkt_err_cnt <= sat_add32(pkt_err_cnt, 32'd1);
              r_prev_valid <= 1'b1;
              r_prev_bpsk  <= w_is_bpsk;
              r_state      <= w_to_resync ? S_RESYNC : S_IDLE;
            end else begin
              r_state <= S_IN_FRAME;
            end
          end
          default: if (data_tlast) r_state <= S_IDLE;
        endcase
      end
      // NOTE: the last non-blocking assignment in the block wins, so a clear overrides
      // any same-cycle increment without extra priority logic.
      if (clear_stats) begin
        pkt_cnt     <= 32'd0;
        pkt_err_cnt <= 32'd0;
        sym_cnt     <= 32'd0;
        bit_err_cnt <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_rx_data_checker.sv
// Self-checking bench for rx_data_checker: packet-level reference model compared every
// cycle, plus directed scenarios with literal expectations and a randomized packet mix.
module tb_rx_data_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  MODE_CTRL;
  logic [15:0] payload_length;
  logic        clear_stats;
  logic [7:0]  data_tdata;
  logic        data_tvalid;
  logic        data_tready;
  logic        data_tlast;
  logic        data_tuser;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_len;
  logic        frame_is_bpsk;
  logic [3:0]  frame_err_flags;
  logic [31:0] pkt_cnt, pkt_err_cnt, sym_cnt, bit_err_cnt;

  rx_data_checker #(.BYTES(1), .EXTRA(3), .MAX_FRAME(1024)) dut (
    .clk(clk), .rst(rst), .MODE_CTRL(MODE_CTRL), .payload_length(payload_length),
    .clear_stats(clear_stats), .data_tdata(data_tdata), .data_tvalid(data_tvalid),
    .data_tready(data_tready), .data_tlast(data_tlast), .data_tuser(data_tuser),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len),
    .frame_is_bpsk(frame_is_bpsk), .frame_err_flags(frame_err_flags),
    .pkt_cnt(pkt_cnt), .pkt_err_cnt(pkt_err_cnt), .sym_cnt(sym_cnt),
    .bit_err_cnt(bit_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: whole packets held in a queue ----------------
  typedef struct packed { logic u; logic [7:0] d; } beat_t;
  beat_t q[$];
  bit    started = 0;
  bit    resync, prev_valid, prev_bpsk;
  logic [3:0]  cap_mode;
  int          cap_exp;
  logic        exp_tready, exp_done, exp_ok, exp_isb;
  logic [15:0] exp_len;
  logic [3:0]  exp_flags;
  logic [31:0] exp_pkt, exp_perr, exp_sym, exp_bec;

  function automatic int beat_errors(input logic [7:0] d, input logic u);
    int n = 0;
    for (int i = 1; i < 8; i++) if (d[i] != d[7]) n++;
    if (u && d[0] != d[7]) n++;
    return n;
  endfunction

  task automatic model_close(input bit forced);
    int         errs = 0;
    bit         mode_err = 0;
    bit         isb;
    logic [3:0] fl;
    isb = q[0].u;
    foreach (q[i]) begin
      errs += beat_errors(q[i].d, q[i].u);
      if (q[i].u != isb) mode_err = 1;
    end
    if (cap_mode == 4'b0001 && !isb) mode_err = 1;
    if (cap_mode == 4'b0010 && isb)  mode_err = 1;
    fl[0] = forced || (q.size() != cap_exp);
    fl[1] = (errs != 0);
    fl[2] = mode_err;
    fl[3] = (cap_mode != 4'b0001 && cap_mode != 4'b0010) && prev_valid && (isb == prev_bpsk);
    exp_done  = 1;
    exp_ok    = (fl == 4'd0);
    exp_len   = 16'(q.size());
    exp_isb   = isb;
    exp_flags = fl;
    exp_pkt   = exp_pkt + 1;
    if (fl != 4'd0) exp_perr = exp_perr + 1;
    prev_valid = 1;
    prev_bpsk  = isb;
    q.delete();
  endtask

  always @(posedge clk) begin
    bit beat;
    started = 1;
    if (rst) begin
      q.delete();
      resync = 0; prev_valid = 0; prev_bpsk = 0;
      exp_tready = 0; exp_done = 0; exp_ok = 0; exp_isb = 0; exp_len = 0; exp_flags = 0;
      exp_pkt = 0; exp_perr = 0; exp_sym = 0; exp_bec = 0;
    end else begin
      beat = data_tvalid && exp_tready;
      exp_tready = 1;
      exp_done   = 0;
      if (beat) begin
        exp_sym = exp_sym + 1;
        if (resync) begin
          if (data_tlast) resync = 0;
        end else begin
          if (q.size() == 0) begin
            cap_mode = MODE_CTRL;
            cap_exp  = (data_tuser ? int'(payload_length) : int'(payload_length) / 2) + 3;
          end
          q.push_back('{u: data_tuser, d: data_tdata});
          exp_bec = exp_bec + 32'(beat_errors(data_tdata, data_tuser));
          if (data_tlast) model_close(0);
          else if (q.size() == 1024) begin
            model_close(1);
            resync = 1;
          end
        end
      end
      if (clear_stats) begin
        exp_pkt = 0; exp_perr = 0; exp_sym = 0; exp_bec = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("tready",      data_tready,     exp_tready);
      check("frame_done",  frame_done,      exp_done);
      check("frame_ok",    frame_ok,        exp_ok);
      check("frame_len",   frame_len,       exp_len);
      check("frame_bpsk",  frame_is_bpsk,   exp_isb);
      check("flags",       frame_err_flags, exp_flags);
      check("pkt_cnt",     pkt_cnt,         exp_pkt);
      check("pkt_err_cnt", pkt_err_cnt,     exp_perr);
      check("sym_cnt",     sym_cnt,         exp_sym);
      check("bit_err_cnt", bit_err_cnt,     exp_bec);
    end
  end

  // ---------------- stimulus ----------------
  bit gaps_en = 0, clr_on_last = 0, rnd_clr_en = 0;

  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    int guard = 0;
    if (gaps_en) begin
      data_tvalid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    data_tvalid = 1; data_tdata = d; data_tuser = u; data_tlast = l;
    clear_stats = (l & clr_on_last) | (rnd_clr_en && $urandom_range(0, 99) == 0);
    forever begin
      @(negedge clk);
      if (data_tready) break;
      guard++;
      if (guard > 20) begin
        check("tready_timeout", {31'd0, data_tready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    data_tvalid = 0; data_tlast = 0; clear_stats = 0;
  endtask

  task automatic send_pkt(input int n, input logic u, input int last_at, input int flip_at,
                          input int e1, input logic [7:0] v1, input int e2, input logic [7:0] v2);
    for (int i = 1; i <= n; i++) begin
      logic       uu;
      logic [7:0] d;
      uu = (flip_at != 0 && i >= flip_at) ? ~u : u;
      d  = uu ? ((i % 2 == 1) ? 8'hFF : 8'h00) : ((i % 2 == 1) ? 8'hFE : 8'h01);
      if (i == e1) d = v1;
      if (i == e2) d = v2;
      send_beat(d, uu, i == last_at);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; MODE_CTRL = 4'b0001; payload_length = 16'd128; clear_stats = 0;
    data_tdata = 0; data_tvalid = 0; data_tlast = 0; data_tuser = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_pkt_cnt", pkt_cnt, 0);
    check("reset_done", {31'd0, frame_done}, 0);

    // BPSK clean packet
    send_pkt(131, 1, 131, 0, 0, 8'h00, 0, 8'h00);
    check("s1_done", {31'd0, frame_done}, 1);
    check("s1_ok", {31'd0, frame_ok}, 1);
    check("s1_len", frame_len, 131);
    check("s1_pkt", pkt_cnt, 1);
    check("s1_bec", bit_err_cnt, 0);

    // QPSK clean packet
    MODE_CTRL = 4'b0010;
    send_pkt(67, 0, 67, 0, 0, 8'h00, 0, 8'h00);
    check("s2_ok", {31'd0, frame_ok}, 1);
    check("s2_len", frame_len, 67);
    check("s2_bpsk", {31'd0, frame_is_bpsk}, 0);

    // BPSK with two single-bit errors
    MODE_CTRL = 4'b0001;
    send_pkt(131, 1, 131, 0, 10, 8'hF7, 20, 8'h01);
    check("s3_flags", frame_err_flags, 4'b0010);
    check("s3_bec", bit_err_cnt, 2);
    check("s3_perr", pkt_err_cnt, 1);

    // Short QPSK packet, then runaway packet forcing a MAX_FRAME close and RESYNC
    MODE_CTRL = 4'b0010;
    send_pkt(60, 0, 60, 0, 0, 8'h00, 0, 8'h00);
    check("s4_flags", frame_err_flags, 4'b0001);
    check("s4_len", frame_len, 60);
    send_pkt(1100, 0, 1100, 0, 0, 8'h00, 0, 8'h00);
    check("s4_maxlen", frame_len, 1024);
    check("s4_maxflags", frame_err_flags, 4'b0001);
    check("s4_pkt", pkt_cnt, 5);
    check("s4_sym", sym_cnt, 131 + 67 + 131 + 60 + 1100);

    // MIX mode alternation and mid-packet modulation flip
    MODE_CTRL = 4'b0100;
    send_pkt(131, 1, 131, 0, 0, 8'h00, 0, 8'h00);
    check("s5_a_flags", frame_err_flags, 4'b0000);
    send_pkt(131, 1, 131, 0, 0, 8'h00, 0, 8'h00);
    check("s5_b_flags", frame_err_flags, 4'b1000);
    send_pkt(67, 0, 67, 0, 0, 8'h00, 0, 8'h00);
    check("s5_c_flags", frame_err_flags, 4'b0000);
    send_pkt(131, 1, 131, 50, 0, 8'h00, 0, 8'h00);
    check("s5_d_flags", frame_err_flags, 4'b0100);

    // Gapped traffic, reset mid-packet, clean recovery, clear on the closing beat
    MODE_CTRL = 4'b0001;
    gaps_en = 1;
    send_pkt(50, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    do_reset();
    check("s6_rst_pkt", pkt_cnt, 0);
    check("s6_rst_done", {31'd0, frame_done}, 0);
    send_pkt(131, 1, 131, 0, 0, 8'h00, 0, 8'h00);
    check("s6_ok", {31'd0, frame_ok}, 1);
    check("s6_pkt", pkt_cnt, 1);
    clr_on_last = 1;
    send_pkt(131, 1, 131, 0, 0, 8'h00, 0, 8'h00);
    clr_on_last = 0;
    check("s6_clr_done", {31'd0, frame_done}, 1);
    check("s6_clr_pkt", pkt_cnt, 0);
    check("s6_clr_sym", sym_cnt, 0);

    // Randomized packet mix against the model
    rnd_clr_en = 1;
    for (int p = 0; p < 30; p++) begin
      int   n;
      logic u;
      case ($urandom_range(0, 3))
        0:       MODE_CTRL = 4'b0001;
        1:       MODE_CTRL = 4'b0010;
        2:       MODE_CTRL = 4'b0100;
        default: MODE_CTRL = 4'($urandom);
      endcase
      payload_length = 16'($urandom_range(2, 40));
      u = 1'($urandom_range(0, 1));
      n = (u ? int'(payload_length) : int'(payload_length) / 2) + 3;
      if ($urandom_range(0, 3) == 0) n = n + int'($urandom_range(0, 4)) - 2;
      for (int i = 1; i <= n; i++) begin
        logic       uu;
        logic [7:0] d;
        uu = ($urandom_range(0, 19) == 0) ? ~u : u;
        d  = uu ? ((i % 2 == 1) ? 8'hFF : 8'h00) : ((i % 2 == 1) ? 8'hFE : 8'h01);
        if ($urandom_range(0, 7) == 0) d = 8'($urandom);
        send_beat(d, uu, i == n);
      end
    end
    rnd_clr_en = 0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
